// File: rtl/count_capture_fifo.sv
// Captures counter values into a small FIFO on a capture strobe edge or on counter wrap.
// Also reports wrap events and a sticky overflow when a capture is dropped.
module count_capture_fifo #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  cnt_in,
  input  logic              cnt_en,
  input  logic              capture,
  input  logic              auto_mode,
  input  logic              rd_en,
  input  logic              clr_ovf,
  output logic [WIDTH-1:0]  rd_data,
  output logic              rd_valid,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   level,
  output logic              wrap_evt,
  output logic              overflow
);

  localparam logic [ADDR_W:0] FULL_LVL = (ADDR_W+1)'(DEPTH);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [ADDR_W:0]   level_q, level_d;
  logic [WIDTH-1:0]  prev_cnt_q;
  logic              prev_valid_q;
  logic              capture_q;
  logic              wrap_evt_q;
  logic              overflow_q, overflow_d;
  logic [WIDTH-1:0]  rd_data_q;
  logic              rd_valid_q;

  logic wrap, wr_req, rd_req, wr_acc, wr_drop;

  assign empty = (level_q == '0);
  assign full  = (level_q == FULL_LVL);

  always_comb begin
    wrap = 1'b0;
    if (prev_valid_q && cnt_en) begin
      if ((prev_cnt_q == '1 && cnt_in == '0) || (prev_cnt_q == '0 && cnt_in == '1))
        wrap = 1'b1;
    end
  end

  assign wr_req  = (capture & ~capture_q) | (auto_mode & wrap);
  assign rd_req  = rd_en & ~empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the write.
  assign wr_acc  = wr_req & (~full | rd_req);
  assign wr_drop = wr_req & full & ~rd_req;

  always_comb begin
    level_d = level_q;
    case ({wr_acc, rd_req})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_comb begin
    overflow_d = overflow_q;
    if (clr_ovf) overflow_d = 1'b0;
    if (wr_drop) overflow_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      prev_cnt_q   <= '0;
      prev_valid_q <= 1'b0;
      capture_q    <= 1'b0;
      wrap_evt_q   <= 1'b0;
      overflow_q   <= 1'b0;
      rd_data_q    <= '0;
      rd_valid_q   <= 1'b0;
    end else begin
      prev_cnt_q   <= cnt_in;
      prev_valid_q <= 1'b1;
      capture_q    <= capture;
      wrap_evt_q   <= wrap;
      overflow_q   <= overflow_d;
      level_q      <= level_d;
      rd_valid_q   <= rd_req;
      if (wr_acc) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_req) begin
        rd_data_q <= mem[rd_ptr_q];
        rd_ptr_q  <= rd_ptr_q + 1'b1;
      end
    end
  end

  // Storage is not reset; pointers and level define what is valid.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr_q] <= cnt_in;
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign level    = level_q;
  assign wrap_evt = wrap_evt_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_count_capture_fifo.sv
// Directed self-checking bench for count_capture_fifo.
module tb_count_capture_fifo;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] cnt_in;
  logic       cnt_en, capture, auto_mode, rd_en, clr_ovf;
  logic [7:0] rd_data;
  logic       rd_valid, empty, full, wrap_evt, overflow;
  logic [3:0] level;

  int tests = 0;
  int fails = 0;

  count_capture_fifo #(.WIDTH(8), .DEPTH(8), .ADDR_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .cnt_in(cnt_in), .cnt_en(cnt_en),
    .capture(capture), .auto_mode(auto_mode), .rd_en(rd_en), .clr_ovf(clr_ovf),
    .rd_data(rd_data), .rd_valid(rd_valid), .empty(empty), .full(full),
    .level(level), .wrap_evt(wrap_evt), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cnt_in = 8'h05; cnt_en = 1'b0; capture = 1'b0;
    auto_mode = 1'b0; rd_en = 1'b0; clr_ovf = 1'b0;
    tick(); tick();
    tests++; if (empty !== 1'b1 || level !== 4'd0 || overflow !== 1'b0 || rd_valid !== 1'b0 || rd_data !== 8'h00) begin
      fails++; $display("FAIL reset: empty=%0b level=%0d ovf=%0b rv=%0b rd=%0h, want 1 0 0 0 00", empty, level, overflow, rd_valid, rd_data);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      tests++; if (wrap_evt !== 1'b0 || empty !== 1'b1 || level !== 4'd0) begin
        fails++; $display("FAIL idle: wrap=%0b empty=%0b level=%0d, want 0 1 0", wrap_evt, empty, level);
      end
    end
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    tests++; if (rd_valid !== 1'b0 || level !== 4'd0 || rd_data !== 8'h00) begin
      fails++; $display("FAIL rd_empty: rv=%0b level=%0d rd=%0h, want 0 0 00", rd_valid, level, rd_data);
    end
  endtask

  task automatic test_manual_capture();
    capture = 1'b1;
    cnt_in = 8'd10; tick();
    cnt_in = 8'd11; tick();
    cnt_in = 8'd12; tick();
    capture = 1'b0; tick();
    tests++; if (level !== 4'd1) begin
      fails++; $display("FAIL manual_level: got %0d want 1", level);
    end
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    tests++; if (rd_data !== 8'd10 || rd_valid !== 1'b1 || empty !== 1'b1) begin
      fails++; $display("FAIL manual_pop: rd=%0d rv=%0b empty=%0b, want 10 1 1", rd_data, rd_valid, empty);
    end
    tick();
    tests++; if (rd_valid !== 1'b0) begin
      fails++; $display("FAIL rv_pulse: got %0b want 0", rd_valid);
    end
  endtask

  task automatic test_auto_wrap();
    logic [7:0] up_seq [6];
    logic [7:0] dn_seq [4];
    int pulses;
    up_seq = '{8'hFD, 8'hFE, 8'hFF, 8'h00, 8'h01, 8'h02};
    dn_seq = '{8'h01, 8'h00, 8'hFF, 8'hFE};
    auto_mode = 1'b1; cnt_en = 1'b1;
    pulses = 0;
    foreach (up_seq[i]) begin
      cnt_in = up_seq[i]; tick();
      if (wrap_evt === 1'b1) pulses++;
      if (i == 3) begin
        tests++; if (wrap_evt !== 1'b1) begin
          fails++; $display("FAIL up_wrap_timing: got %0b want 1", wrap_evt);
        end
      end
    end
    tests++; if (pulses != 1 || level !== 4'd1) begin
      fails++; $display("FAIL up_wrap: pulses=%0d level=%0d, want 1 1", pulses, level);
    end
    pulses = 0;
    foreach (dn_seq[i]) begin
      cnt_in = dn_seq[i]; tick();
      if (wrap_evt === 1'b1) pulses++;
    end
    tests++; if (pulses != 1 || level !== 4'd2) begin
      fails++; $display("FAIL down_wrap: pulses=%0d level=%0d, want 1 2", pulses, level);
    end
    rd_en = 1'b1; tick();
    tests++; if (rd_data !== 8'h00 || rd_valid !== 1'b1) begin
      fails++; $display("FAIL auto_pop0: rd=%0h rv=%0b, want 00 1", rd_data, rd_valid);
    end
    tick(); rd_en = 1'b0;
    tests++; if (rd_data !== 8'hFF || rd_valid !== 1'b1) begin
      fails++; $display("FAIL auto_pop1: rd=%0h rv=%0b, want ff 1", rd_data, rd_valid);
    end
    cnt_en = 1'b0;
    cnt_in = 8'hFF; tick();
    cnt_in = 8'h00; tick();
    tests++; if (wrap_evt !== 1'b0 || level !== 4'd0) begin
      fails++; $display("FAIL no_en_wrap: wrap=%0b level=%0d, want 0 0", wrap_evt, level);
    end
    auto_mode = 1'b0;
  endtask

  task automatic test_full_overflow();
    for (int i = 1; i <= 8; i++) begin
      cnt_in = 8'(i); capture = 1'b1; tick();
      capture = 1'b0; tick();
    end
    tests++; if (full !== 1'b1 || level !== 4'd8 || overflow !== 1'b0) begin
      fails++; $display("FAIL fill: full=%0b level=%0d ovf=%0b, want 1 8 0", full, level, overflow);
    end
    cnt_in = 8'd9; capture = 1'b1; tick(); capture = 1'b0;
    tests++; if (overflow !== 1'b1 || level !== 4'd8) begin
      fails++; $display("FAIL overflow_set: ovf=%0b level=%0d, want 1 8", overflow, level);
    end
    tick();
    capture = 1'b1; clr_ovf = 1'b1; tick(); capture = 1'b0; clr_ovf = 1'b0;
    tests++; if (overflow !== 1'b1) begin
      fails++; $display("FAIL set_wins: got %0b want 1", overflow);
    end
    tick();
    clr_ovf = 1'b1; tick(); clr_ovf = 1'b0;
    tests++; if (overflow !== 1'b0) begin
      fails++; $display("FAIL clr_ovf: got %0b want 0", overflow);
    end
  endtask

  task automatic test_simultaneous();
    logic [7:0] exp [8];
    exp = '{8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'h55};
    cnt_in = 8'h55; capture = 1'b1; rd_en = 1'b1; tick();
    capture = 1'b0; rd_en = 1'b0;
    tests++; if (level !== 4'd8 || overflow !== 1'b0 || rd_data !== 8'd1 || rd_valid !== 1'b1) begin
      fails++; $display("FAIL full_wr_rd: level=%0d ovf=%0b rd=%0h rv=%0b, want 8 0 01 1", level, overflow, rd_data, rd_valid);
    end
    tick();
    rd_en = 1'b1;
    foreach (exp[i]) begin
      tick();
      tests++; if (rd_data !== exp[i] || rd_valid !== 1'b1) begin
        fails++; $display("FAIL drain%0d: rd=%0h rv=%0b, want %0h 1", i, rd_data, rd_valid, exp[i]);
      end
    end
    rd_en = 1'b0;
    tests++; if (empty !== 1'b1) begin
      fails++; $display("FAIL drained_empty: got %0b want 1", empty);
    end
    cnt_in = 8'h77; capture = 1'b1; rd_en = 1'b1; tick();
    capture = 1'b0; rd_en = 1'b0;
    tests++; if (level !== 4'd1 || rd_valid !== 1'b0 || rd_data !== 8'h55) begin
      fails++; $display("FAIL empty_wr_rd: level=%0d rv=%0b rd=%0h, want 1 0 55", level, rd_valid, rd_data);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    cnt_in = 8'h21; capture = 1'b1; tick(); capture = 1'b0; tick();
    cnt_in = 8'h22; capture = 1'b1; tick(); capture = 1'b0; tick();
    tests++; if (level !== 4'd3) begin
      fails++; $display("FAIL pre_reset_level: got %0d want 3", level);
    end
    auto_mode = 1'b1; cnt_en = 1'b1; cnt_in = 8'hFF; tick();
    #2 rst_n = 1'b0;
    #1;
    tests++; if (empty !== 1'b1 || level !== 4'd0) begin
      fails++; $display("FAIL async_reset: empty=%0b level=%0d, want 1 0", empty, level);
    end
    #1 rst_n = 1'b1;
    cnt_in = 8'h00; tick();
    tests++; if (wrap_evt !== 1'b0 || level !== 4'd0) begin
      fails++; $display("FAIL post_reset_wrap: wrap=%0b level=%0d, want 0 0", wrap_evt, level);
    end
    tick();
    tests++; if (wrap_evt !== 1'b0) begin
      fails++; $display("FAIL post_reset_wrap2: got %0b want 0", wrap_evt);
    end
    auto_mode = 1'b0; cnt_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_manual_capture();
    test_auto_wrap();
    test_full_overflow();
    test_simultaneous();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
